// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// classic five-stage indices and the default performance-counter width.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int NB_CNT_DEFAULT = 32;

endpackage

// File: rtl/pipe_valid_chain.sv
// Per-stage valid shift register: shifts on advance, holds the front of the
// pipe and inserts a bubble on stall, clears the leading stages on flush.
module pipe_valid_chain
    import mips_pkg::*;
#(
    parameter int N_STAGES    = 5,
    parameter int STALL_STAGE = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_advance,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_fill,
    input  logic                i_kill,
    output logic [N_STAGES-1:0] o_valid,
    output logic [N_STAGES-1:0] o_valid_d
);

    logic [N_STAGES-1:0] valid_q;
    logic [N_STAGES-1:0] valid_d;
    logic [N_STAGES-1:0] shifted;

    // Stall takes priority over flush; a kill (halt) always empties the fetch slot.
    always_comb begin
        shifted = {valid_q[N_STAGES-2:0], i_fill};
        valid_d = valid_q;
        if (i_advance) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (i_stall && i < STALL_STAGE) begin
                    valid_d[i] = valid_q[i];
                end else if (i_stall && i == STALL_STAGE) begin
                    valid_d[i] = 1'b0;
                end else if (!i_stall && i_flush && i < FLUSH_DEPTH) begin
                    valid_d[i] = 1'b0;
                end else begin
                    valid_d[i] = shifted[i];
                end
            end
            if (i_kill) begin
                valid_d[STG_IF] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_valid_d = valid_d;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: run / single-step / drain / halt FSM with
// stall and flush handling. Define PIPELINE_CTRL_PERF_CNT_EN for the counters.
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int N_STAGES    = 5,
    parameter int STALL_STAGE = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int NB_CNT      = NB_CNT_DEFAULT
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_step_mode,
    input  logic                i_run,
    input  logic                i_step,
    input  logic                i_clear,
    input  logic                i_halt_req,
    input  logic                i_halt_instr,
    input  logic                i_stall,
    input  logic                i_flush,
    output logic                o_pc_en,
    output logic [N_STAGES-1:0] o_stage_en,
    output logic [N_STAGES-1:0] o_stage_valid,
    output logic [2:0]          o_state,
    output logic                o_halted,
    output logic [NB_CNT-1:0]   o_cycle_cnt,
    output logic [NB_CNT-1:0]   o_retired_cnt
);

    state_e              state_q;
    state_e              state_d;
    logic                active;
    logic                advance;
    logic                stall_eff;
    logic                flush_eff;
    logic                halt_hit;
    logic [N_STAGES-1:0] valid_q;
    logic [N_STAGES-1:0] valid_d;

    // Hazard inputs only matter while fetching; the drain ignores them so it
    // is guaranteed to finish within N_STAGES cycles.
    always_comb begin
        active    = (state_q == ST_RUN) || (state_q == ST_STEP);
        advance   = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                    ((state_q == ST_STEP) && i_step);
        stall_eff = advance && active && i_stall;
        flush_eff = advance && active && i_flush && !i_stall;
        halt_hit  = advance && active &&
                    (i_halt_req || (i_halt_instr && valid_q[STG_ID]));
        o_pc_en   = advance && !stall_eff && (state_q != ST_DRAIN);
        o_stage_en = '0;
        if (advance) begin
            for (int i = 0; i < N_STAGES; i++) begin
                o_stage_en[i] = !stall_eff || (i >= STALL_STAGE);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (i_run) state_d = i_step_mode ? ST_STEP : ST_RUN;
            ST_RUN:    if (halt_hit) state_d = ST_DRAIN;
            ST_STEP:   if (halt_hit) state_d = ST_DRAIN;
            ST_DRAIN:  if (valid_d == '0) state_d = ST_HALTED;
            ST_HALTED: if (i_clear) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_valid_chain #(
        .N_STAGES    (N_STAGES),
        .STALL_STAGE (STALL_STAGE),
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) u_valid_chain (
        .clk       (clk),
        .rst       (i_rst),
        .i_advance (advance),
        .i_stall   (stall_eff),
        .i_flush   (flush_eff),
        .i_fill    (active),
        .i_kill    (halt_hit),
        .o_valid   (valid_q),
        .o_valid_d (valid_d)
    );

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [NB_CNT-1:0] cycle_cnt_q;
    logic [NB_CNT-1:0] cycle_cnt_d;
    logic [NB_CNT-1:0] retired_cnt_q;
    logic [NB_CNT-1:0] retired_cnt_d;

    // An instruction counts as retired on the advance that moves it into WB.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if ((state_q == ST_HALTED) && i_clear) begin
            cycle_cnt_d   = '0;
            retired_cnt_d = '0;
        end else if (advance) begin
            cycle_cnt_d = cycle_cnt_q + NB_CNT'(1);
            if (valid_d[N_STAGES-1]) begin
                retired_cnt_d = retired_cnt_q + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign o_cycle_cnt   = cycle_cnt_q;
    assign o_retired_cnt = retired_cnt_q;
`else
    assign o_cycle_cnt   = '0;
    assign o_retired_cnt = '0;
`endif

    assign o_stage_valid = valid_q;
    assign o_state       = state_q;
    assign o_halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a behavioural model checked every
// negedge plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_ctrl;

    localparam int N  = 5;
    localparam int SS = 2;
    localparam int FD = 1;
    localparam int NB = 32;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

    logic          clk;
    logic          i_rst, i_step_mode, i_run, i_step, i_clear;
    logic          i_halt_req, i_halt_instr, i_stall, i_flush;
    logic          o_pc_en, o_halted;
    logic [N-1:0]  o_stage_en, o_stage_valid;
    logic [2:0]    o_state;
    logic [NB-1:0] o_cycle_cnt, o_retired_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_ctrl #(
        .N_STAGES(N), .STALL_STAGE(SS), .FLUSH_DEPTH(FD), .NB_CNT(NB)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_step_mode(i_step_mode), .i_run(i_run),
        .i_step(i_step), .i_clear(i_clear), .i_halt_req(i_halt_req),
        .i_halt_instr(i_halt_instr), .i_stall(i_stall), .i_flush(i_flush),
        .o_pc_en(o_pc_en), .o_stage_en(o_stage_en), .o_stage_valid(o_stage_valid),
        .o_state(o_state), .o_halted(o_halted), .o_cycle_cnt(o_cycle_cnt),
        .o_retired_cnt(o_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic logic [63:0] cnt_exp(input logic [63:0] v);
        return PERF ? v : 64'd0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: state, valid vector and counts, updated from the rules.
    int            m_mode = M_IDLE;
    logic [N-1:0]  m_valid = '0;
    logic [NB-1:0] m_cyc = '0;
    logic [NB-1:0] m_ret = '0;

    always @(negedge clk) begin : model_check
        logic         adv, act, stl, fl, hlt;
        logic [N-1:0] e_en, nv;
        if (i_rst) begin
            m_mode = M_IDLE; m_valid = '0; m_cyc = '0; m_ret = '0;
        end
        act  = (m_mode == M_RUN) || (m_mode == M_STEP);
        adv  = !i_rst && ((m_mode == M_RUN) || (m_mode == M_DRAIN) ||
                          ((m_mode == M_STEP) && i_step));
        stl  = adv && act && i_stall;
        fl   = adv && act && i_flush && !i_stall;
        hlt  = adv && act && (i_halt_req || (i_halt_instr && m_valid[1]));
        e_en = !adv ? '0 : (stl ? ({N{1'b1}} << SS) : {N{1'b1}});

        check_output("m_state", 64'(o_state), 64'(m_mode));
        check_output("m_halted", 64'(o_halted), 64'(m_mode == M_HALTED));
        check_output("m_valid", 64'(o_stage_valid), 64'(m_valid));
        check_output("m_stage_en", 64'(o_stage_en), 64'(e_en));
        check_output("m_pc_en", 64'(o_pc_en), 64'(adv && !stl && m_mode != M_DRAIN));
        check_output("m_cycle_cnt", 64'(o_cycle_cnt), cnt_exp(64'(m_cyc)));
        check_output("m_retired_cnt", 64'(o_retired_cnt), cnt_exp(64'(m_ret)));

        if (adv) begin
            if (stl) begin
                nv = m_valid;
                for (int i = SS + 1; i < N; i++) nv[i] = m_valid[i-1];
                nv[SS] = 1'b0;
            end else begin
                nv = {m_valid[N-2:0], act};
                if (fl) for (int i = 0; i < FD; i++) nv[i] = 1'b0;
            end
            if (hlt) nv[0] = 1'b0;
            m_cyc = m_cyc + 1;
            if (nv[N-1]) m_ret = m_ret + 1;
            m_valid = nv;
            if (hlt) m_mode = M_DRAIN;
            else if (m_mode == M_DRAIN && nv == '0) m_mode = M_HALTED;
        end else if (!i_rst) begin
            if (m_mode == M_IDLE && i_run) m_mode = i_step_mode ? M_STEP : M_RUN;
            else if (m_mode == M_HALTED && i_clear) begin
                m_mode = M_IDLE; m_cyc = '0; m_ret = '0;
            end
        end
    end

    task automatic apply_stimulus(input logic run, input logic step, input logic stall,
                                  input logic flush, input logic halt_instr,
                                  input logic halt_req, input logic clear);
        i_run = run; i_step = step; i_stall = stall; i_flush = flush;
        i_halt_instr = halt_instr; i_halt_req = halt_req; i_clear = clear;
    endtask

    initial begin : stimulus
        int k;
        i_rst = 1'b1; i_step_mode = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick(2);
        check_output("rst_state", 64'(o_state), 64'd0);
        check_output("rst_valid", 64'(o_stage_valid), 64'd0);
        check_output("rst_en", 64'(o_stage_en), 64'd0);
        i_rst = 1'b0;
        tick(2);
        check_output("idle_no_adv_en", 64'(o_stage_en), 64'd0);
        check_output("idle_no_adv_pc", 64'(o_pc_en), 64'd0);

        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick(10);
        check_output("run10_valid", 64'(o_stage_valid), 64'h1f);
        check_output("run10_cycle", 64'(o_cycle_cnt), cnt_exp(10));
        check_output("run10_retired", 64'(o_retired_cnt), cnt_exp(6));

        apply_stimulus(0, 0, 1, 0, 0, 0, 0);
        #1;
        check_output("stall_en", 64'(o_stage_en), 64'b11100);
        check_output("stall_pc", 64'(o_pc_en), 64'd0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("stall_valid", 64'(o_stage_valid), 64'b11011);

        apply_stimulus(0, 0, 1, 1, 0, 0, 0);
        #1;
        check_output("stflush_en", 64'(o_stage_en), 64'b11100);
        check_output("stflush_pc", 64'(o_pc_en), 64'd0);
        tick(1);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0);
        #1;
        check_output("stflush_valid", 64'(o_stage_valid), 64'b10011);
        check_output("flush_en", 64'(o_stage_en), 64'b11111);
        check_output("flush_pc", 64'(o_pc_en), 64'd1);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("flush_valid", 64'(o_stage_valid), 64'b00110);

        tick(5);
        check_output("refill_valid", 64'(o_stage_valid), 64'h1f);
        check_output("refill_cycle", 64'(o_cycle_cnt), cnt_exp(18));
        check_output("refill_retired", 64'(o_retired_cnt), cnt_exp(11));

        apply_stimulus(0, 0, 0, 0, 1, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("halt_state", 64'(o_state), 64'd3);
        check_output("halt_valid", 64'(o_stage_valid), 64'b11110);
        k = 0;
        while (!o_halted && k < 5) begin
            tick(1);
            k++;
        end
        check_output("drain_halted", 64'(o_halted), 64'd1);
        check_output("drain_cycles", 64'(k), 64'd4);
        check_output("drain_retired", 64'(o_retired_cnt), cnt_exp(15));
        check_output("drain_cycle", 64'(o_cycle_cnt), cnt_exp(23));

        apply_stimulus(1, 1, 0, 0, 0, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("halted_ignores_run", 64'(o_state), 64'd4);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("clear_state", 64'(o_state), 64'd0);
        check_output("clear_cycle", 64'(o_cycle_cnt), 64'd0);
        check_output("clear_retired", 64'(o_retired_cnt), 64'd0);

        i_step_mode = 1'b1;
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        i_step_mode = 1'b0;
        check_output("step_state", 64'(o_state), 64'd2);
        for (int p = 0; p < 3; p++) begin
            apply_stimulus(0, 1, 0, 0, 0, 0, 0);
            tick(1);
            apply_stimulus(0, 0, 0, 0, 0, 0, 0);
            #1;
            check_output("step_gap_en", 64'(o_stage_en), 64'd0);
            tick(3);
        end
        check_output("step_cycle", 64'(o_cycle_cnt), cnt_exp(3));
        check_output("step_valid", 64'(o_stage_valid), 64'b00111);

        apply_stimulus(0, 1, 0, 0, 0, 1, 0);
        tick(1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("stephalt_state", 64'(o_state), 64'd3);
        check_output("stephalt_valid", 64'(o_stage_valid), 64'b01110);
        tick(1);
        check_output("middrain_valid", 64'(o_stage_valid), 64'b11100);
        check_output("middrain_retired", 64'(o_retired_cnt), cnt_exp(1));
        i_rst = 1'b1;
        #1;
        check_output("rst_drain_state", 64'(o_state), 64'd0);
        check_output("rst_drain_valid", 64'(o_stage_valid), 64'd0);
        check_output("rst_drain_en", 64'(o_stage_en), 64'd0);
        check_output("rst_drain_pc", 64'(o_pc_en), 64'd0);
        check_output("rst_drain_halted", 64'(o_halted), 64'd0);
        check_output("rst_drain_cycle", 64'(o_cycle_cnt), 64'd0);
        check_output("rst_drain_retired", 64'(o_retired_cnt), 64'd0);
        tick(2);
        i_rst = 1'b0;
        tick(2);
        check_output("post_rst_idle", 64'(o_state), 64'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
